multicycle_controller: RTL and testbench

- Control unit for the multicycle RV32I core subset (lw, sw, R-type, I-type ALU, beq, jal).
- Drives the 3-bit alu_control word consumed by the core ALU, plus every datapath enable and mux select.
- Implemented as a Moore FSM plus a combinational ALU decoder. The single Mealy term is pc_write, which depends on the ALU zero flag.
- Sits between the instruction register and the datapath.

---
 rtl/multicycle_pkg.sv | 41 ++++
 rtl/alu_decoder.sv | 31 +++
 rtl/multicycle_controller.sv | 152 +++++++++++++++
 tb/tb_multicycle_controller.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, opcodes,
// ALU control words and the internal alu_op codes.
package multicycle_pkg;

    localparam int unsigned OP_W      = 7;
    localparam int unsigned ALU_CTL_W = 3;
    localparam int unsigned ALU_OP_W  = 2;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWRITE,
        S_MEMWB,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_JAL,
        S_BEQ
    } state_t;

    localparam logic [OP_W-1:0] OP_LW     = 7'b0000011;
    localparam logic [OP_W-1:0] OP_SW     = 7'b0100011;
    localparam logic [OP_W-1:0] OP_R      = 7'b0110011;
    localparam logic [OP_W-1:0] OP_I      = 7'b0010011;
    localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;

    // bit2 selects invert-B with carry-in (subtract)
    localparam logic [ALU_CTL_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_CTL_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_CTL_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_CTL_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALU_CTL_W-1:0] ALU_SLT = 3'b111;

    localparam logic [ALU_OP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALU_OP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALU_OP_W-1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: maps alu_op and the instruction funct fields
// onto the 3-bit alu_control word.
module alu_decoder
    import multicycle_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // only R-type (op5=1) can request sub; I-type addi ignores bit30
                    3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control unit: Moore FSM for datapath controls plus ALU decoder.
// Optional bne support is enabled by defining MULTICYCLE_CONTROLLER_BNE_EN.
module multicycle_controller
    import multicycle_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic [2:0] alu_control
);

    state_t     r_state;
    state_t     w_next;
    logic [1:0] w_alu_op;
    logic       w_branch;
    logic       w_pc_update;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic       w_take;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    // next-state logic
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH: w_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXECUTER;
                    OP_I:         w_next = S_EXECUTEI;
                    OP_JAL:       w_next = S_JAL;
                    OP_BRANCH:    w_next = S_BEQ;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEMADR:   w_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  w_next = S_MEMWB;
            S_EXECUTER: w_next = S_ALUWB;
            S_EXECUTEI: w_next = S_ALUWB;
            S_JAL:      w_next = S_ALUWB;
            default:    w_next = S_FETCH;
        endcase
    end

    // Moore output decode
    always_comb begin
        adr_src     = 1'b0;
        w_mem_write = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        w_alu_op    = ALUOP_ADD;
        w_pc_update = 1'b0;
        w_branch    = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_ir_write  = 1'b1;
                alu_src_b   = 2'b10;
                result_src  = 2'b10;
                w_pc_update = 1'b1;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD: adr_src = 1'b1;
            S_MEMWRITE: begin
                adr_src     = 1'b1;
                w_mem_write = 1'b1;
            end
            S_MEMWB: begin
                result_src  = 2'b01;
                w_reg_write = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a = 2'b10;
                w_alu_op  = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                w_alu_op  = ALUOP_FUNCT;
            end
            S_ALUWB: w_reg_write = 1'b1;
            S_JAL: begin
                alu_src_a   = 2'b01;
                alu_src_b   = 2'b10;
                w_pc_update = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                w_alu_op  = ALUOP_SUB;
                w_branch  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:     imm_src = 2'b01;
            OP_BRANCH: imm_src = 2'b10;
            OP_JAL:    imm_src = 2'b11;
            default:   imm_src = 2'b00;
        endcase
    end

`ifdef MULTICYCLE_CONTROLLER_BNE_EN
    assign w_take = (funct3 == 3'b001) ? ~zero : zero;
`else
    assign w_take = zero;
`endif

    // enables are gated by rst_n so none can pulse while reset is held
    assign pc_write  = rst_n & (w_pc_update | (w_branch & w_take));
    assign ir_write  = rst_n & w_ir_write;
    assign reg_write = rst_n & w_reg_write;
    assign mem_write = rst_n & w_mem_write;

    alu_decoder u_alu_decoder (
        .alu_op      (w_alu_op),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (alu_control)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-instruction step model,
// per-cycle compare on the falling edge, and literal CPI/reset expectations.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_step  = 0;
    logic m_rst   = 1'b1;
    logic chk_en  = 1'b0;

    multicycle_controller dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op          (op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .zero        (zero),
        .pc_write    (pc_write),
        .adr_src     (adr_src),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .reg_write   (reg_write),
        .result_src  (result_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .imm_src     (imm_src),
        .alu_control (alu_control)
    );

    always #5 clk = ~clk;

    // ALU operation the instruction's arithmetic means (sub only when asked)
    function automatic logic [2:0] arith(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  return sub ? 3'b110 : 3'b010;
            3'b010:  return 3'b111;
            3'b110:  return 3'b001;
            3'b111:  return 3'b000;
            default: return 3'b010;
        endcase
    endfunction

    // Expected outputs for step k of an instruction; step 0 fetch, step 1 decode.
    // Packing: {pc_write, adr_src, mem_write, ir_write, reg_write,
    //           result_src, alu_src_a, alu_src_b, imm_src, alu_control}
    function automatic logic [15:0] model(input logic [6:0] o, input logic [2:0] f3,
                                          input logic f7, input logic z,
                                          input int k, input logic rst);
        logic pcw = 1'b0, adr = 1'b0, mw = 1'b0, irw = 1'b0, rw = 1'b0;
        logic [1:0] rs = 2'b00, a = 2'b00, b = 2'b00, imm = 2'b00;
        logic [2:0] alu = 3'b010;
        case (o)
            7'b0100011: imm = 2'b01;
            7'b1100011: imm = 2'b10;
            7'b1101111: imm = 2'b11;
            default:    imm = 2'b00;
        endcase
        if (rst || k == 0) begin
            rs = 2'b10; b = 2'b10;
            if (!rst) begin irw = 1'b1; pcw = 1'b1; end
        end else if (k == 1) begin
            a = 2'b01; b = 2'b01;
        end else begin
            case (o)
                7'b0000011: begin
                    if (k == 2) begin a = 2'b10; b = 2'b01; end
                    if (k == 3) adr = 1'b1;
                    if (k == 4) begin rs = 2'b01; rw = 1'b1; end
                end
                7'b0100011: begin
                    if (k == 2) begin a = 2'b10; b = 2'b01; end
                    if (k == 3) begin adr = 1'b1; mw = 1'b1; end
                end
                7'b0110011: begin
                    if (k == 2) begin a = 2'b10; alu = arith(f3, f7); end
                    if (k == 3) rw = 1'b1;
                end
                7'b0010011: begin
                    if (k == 2) begin a = 2'b10; b = 2'b01; alu = arith(f3, 1'b0); end
                    if (k == 3) rw = 1'b1;
                end
                7'b1101111: begin
                    if (k == 2) begin a = 2'b01; b = 2'b10; pcw = 1'b1; end
                    if (k == 3) rw = 1'b1;
                end
                7'b1100011: begin
                    if (k == 2) begin a = 2'b10; alu = 3'b110; pcw = z; end
                end
                default: ;
            endcase
        end
        return {pcw, adr, mw, irw, rw, rs, a, b, imm, alu};
    endfunction

    always @(negedge clk) begin
        logic [15:0] got, exp;
        if (chk_en) begin
            exp = model(op, funct3, funct7b5, zero, m_step, m_rst);
            got = {pc_write, adr_src, mem_write, ir_write, reg_write,
                   result_src, alu_src_a, alu_src_b, imm_src, alu_control};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL outputs t=%0t op=%b f3=%b step=%0d rst=%0d got=%b exp=%b",
                         $time, op, funct3, m_step, m_rst, got, exp);
            end
        end
    end

    task automatic check1(input string name, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%b exp=%b", name, got, exp);
        end
    endtask

    // Run one instruction from FETCH; count cycles until ir_write returns.
    task automatic run(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic z, input int exp_cpi);
        int n = 0;
        op = o; funct3 = f3; funct7b5 = f7; zero = z;
        do begin
            m_step = n;
            @(posedge clk); #1;
            n++;
        end while (ir_write !== 1'b1 && n < 8);
        n_tests++;
        if (n != exp_cpi) begin
            n_fail++;
            $display("FAIL cpi op=%b got=%0d exp=%0d", o, n, exp_cpi);
        end
    endtask

    initial begin
        rst_n = 1'b0; op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b1;
        m_rst = 1'b1; m_step = 0; chk_en = 1'b1;
        #2;
        check1("rst_ir_write", ir_write, 1'b0);
        check1("rst_pc_write", pc_write, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1; m_rst = 1'b0; m_step = 0;

        run(7'b0000011, 3'b010, 1'b0, 1'b1, 5);   // lw
        run(7'b0110011, 3'b000, 1'b1, 1'b0, 4);   // sub
        run(7'b0110011, 3'b000, 1'b0, 1'b0, 4);   // add
        run(7'b0110011, 3'b100, 1'b0, 1'b0, 4);   // unlisted funct3 -> add
        run(7'b0010011, 3'b010, 1'b0, 1'b0, 4);   // slti
        run(7'b0010011, 3'b110, 1'b0, 1'b0, 4);   // ori
        run(7'b0010011, 3'b111, 1'b0, 1'b0, 4);   // andi
        run(7'b0010011, 3'b000, 1'b1, 1'b0, 4);   // addi with bit30 set stays add
        run(7'b1100011, 3'b000, 1'b0, 1'b1, 3);   // beq taken
        run(7'b1100011, 3'b000, 1'b0, 1'b0, 3);   // beq not taken
        run(7'b1100011, 3'b001, 1'b0, 1'b1, 3);   // funct3 ignored in default build
        run(7'b0100011, 3'b010, 1'b0, 1'b0, 4);   // sw
        run(7'b1101111, 3'b000, 1'b0, 1'b0, 4);   // jal
        run(7'b0000000, 3'b000, 1'b0, 1'b1, 2);   // unknown op

        // reset asserted while lw sits in its write-back cycle
        op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
        for (int s = 0; s < 4; s++) begin
            m_step = s;
            @(posedge clk); #1;
        end
        m_step = 4;
        #1 check1("memwb_reg_write", reg_write, 1'b1);
        rst_n = 1'b0; m_rst = 1'b1;
        #1 check1("midrst_reg_write", reg_write, 1'b0);
        check1("midrst_result_src1", result_src[1], 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1; m_rst = 1'b0; m_step = 0;
        #1 check1("post_rst_ir_write", ir_write, 1'b1);
        check1("post_rst_pc_write", pc_write, 1'b1);
        run(7'b0000011, 3'b010, 1'b0, 1'b0, 5);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
